// File: rtl/game_state_ctl_if.sv
// Screen-selector package and the bundle between the game
// timing/input sources and game_state_ctl.
//   master: drives vblnk, mouse, player positions, buttons;
//           reads game_state, level_init, frame_cnt.
//   slave : the controller side (mirror of master).

package state_pkg;
   typedef enum logic [1:0] {
      START   = 2'b00,
      LEVEL_1 = 2'b01,
      FINISH  = 2'b10
   } g_state;
endpackage

interface game_state_ctl_if;
   import state_pkg::*;

   logic        vblnk;
   logic        mouse_left;
   logic [11:0] xpos_mouse;
   logic [11:0] ypos_mouse;
   logic [11:0] xpos_player1;
   logic [11:0] xpos_player2;
   logic [1:0]  button_pressed;
   g_state      game_state;
   logic        level_init;
   logic [7:0]  frame_cnt;

   modport master (
      output vblnk, mouse_left,
      output xpos_mouse, ypos_mouse,
      output xpos_player1, xpos_player2,
      output button_pressed,
      input  game_state, level_init, frame_cnt
   );

   modport slave (
      input  vblnk, mouse_left,
      input  xpos_mouse, ypos_mouse,
      input  xpos_player1, xpos_player2,
      input  button_pressed,
      output game_state, level_init, frame_cnt
   );
endinterface

// File: rtl/game_state_ctl.sv
// Game screen sequencer: START -> LEVEL_1 -> FINISH -> START.
// Ports: clk, rst (async active-low), gs (slave bundle:
//   vblnk, mouse, player x, floor buttons in; game_state,
//   level_init pulse, frame_cnt out). Changes land on vblnk rise.

module game_state_ctl
   import state_pkg::*;
#(
   parameter logic [11:0] START_X0      = 12'd412,
   parameter logic [11:0] START_X1      = 12'd612,
   parameter logic [11:0] START_Y0      = 12'd334,
   parameter logic [11:0] START_Y1      = 12'd434,
   parameter logic [11:0] EXIT_X        = 12'd960,
   parameter int unsigned HOLD_FRAMES   = 30,
   parameter int unsigned FINISH_FRAMES = 180
) (
   input  logic        clk,
   input  logic        rst,
   game_state_ctl_if.slave gs
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
   localparam logic [7:0] FIN_LAST  = 8'(FINISH_FRAMES - 1);

   g_state     state_q, state_d;
   logic       vblnk_d_q, left_d_q;
   logic       click_pend_q, click_pend_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       level_init_q, level_init_d;

   logic frame_tick, click, in_btn, hit, win_ok, chg;

   always_comb begin
      frame_tick = gs.vblnk & ~vblnk_d_q;
      click      = gs.mouse_left & ~left_d_q;
      in_btn     = (gs.xpos_mouse >= START_X0) &&
                   (gs.xpos_mouse <= START_X1) &&
                   (gs.ypos_mouse >= START_Y0) &&
                   (gs.ypos_mouse <= START_Y1);
      hit        = click & in_btn;
      win_ok     = (gs.xpos_player1 >= EXIT_X) &&
                   (gs.xpos_player2 >= EXIT_X) &&
                   (gs.button_pressed == 2'b11);
   end

   // Next state; an unknown encoding falls back to START at once.
   always_comb begin
      state_d = state_q;
      case (state_q)
         START: begin
            if (frame_tick && click_pend_q)
               state_d = LEVEL_1;
         end
         LEVEL_1: begin
            if (frame_tick && win_ok &&
                hold_cnt_q == HOLD_LAST)
               state_d = FINISH;
         end
         FINISH: begin
            if (frame_tick &&
                (click_pend_q || frame_cnt_q == FIN_LAST))
               state_d = START;
         end
         default: state_d = START;
      endcase
   end

   always_comb begin
      chg = (state_d != state_q);

      // A click on the tick cycle itself is dropped.
      click_pend_d = click_pend_q;
      if (click && (state_q == FINISH ||
                    (state_q == START && hit)))
         click_pend_d = 1'b1;
      if (frame_tick)
         click_pend_d = 1'b0;

      hold_cnt_d = hold_cnt_q;
      if (chg)
         hold_cnt_d = 8'd0;
      else if (frame_tick && state_q == LEVEL_1) begin
         if (!win_ok)
            hold_cnt_d = 8'd0;
         else if (hold_cnt_q != 8'hFF)
            hold_cnt_d = hold_cnt_q + 8'd1;
      end

      frame_cnt_d = frame_cnt_q;
      if (chg)
         frame_cnt_d = 8'd0;
      else if (frame_tick && frame_cnt_q != 8'hFF)
         frame_cnt_d = frame_cnt_q + 8'd1;

      level_init_d = chg && (state_d == LEVEL_1);
   end

   // Edge detectors reset high so levels held through
   // reset release never look like fresh edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= START;
         vblnk_d_q    <= 1'b1;
         left_d_q     <= 1'b1;
         click_pend_q <= 1'b0;
         hold_cnt_q   <= 8'd0;
         frame_cnt_q  <= 8'd0;
         level_init_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vblnk_d_q    <= gs.vblnk;
         left_d_q     <= gs.mouse_left;
         click_pend_q <= click_pend_d;
         hold_cnt_q   <= hold_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         level_init_q <= level_init_d;
      end
   end

   assign gs.game_state = state_q;
   assign gs.level_init = level_init_q;
   assign gs.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_game_state_ctl.sv
// Bench for game_state_ctl: directed scenarios plus random
// frames checked against a frame-level model of the game rules.

module tb_game_state_ctl;
   import state_pkg::*;

   localparam int HOLD = 30;
   localparam int FIN  = 180;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   game_state_ctl_if gif();

   game_state_ctl dut (
      .clk (clk),
      .rst (rst_n),
      .gs  (gif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // frame-level model
   g_state m_state;
   bit     m_pend;
   int     m_run;
   int     m_ticks;
   bit     m_init;

   // observations after each tick
   g_state     o_state;
   logic [7:0] o_fcnt;
   logic       o_init;
   logic       o_init2;

   function automatic bit in_box(logic [11:0] x, logic [11:0] y);
      return x >= 412 && x <= 612 && y >= 334 && y <= 434;
   endfunction

   function automatic logic [7:0] exp_fcnt();
      return (m_ticks > 255) ? 8'd255 : 8'(m_ticks);
   endfunction

   task automatic model_reset();
      m_state = START;
      m_pend  = 0;
      m_run   = 0;
      m_ticks = 0;
      m_init  = 0;
   endtask

   task automatic model_tick(input bit win);
      g_state nxt;
      nxt = m_state;
      case (m_state)
         START:   if (m_pend) nxt = LEVEL_1;
         LEVEL_1: begin
            m_run = win ? m_run + 1 : 0;
            if (m_run >= HOLD) nxt = FINISH;
         end
         FINISH:  if (m_pend || m_ticks + 1 >= FIN) nxt = START;
         default: nxt = START;
      endcase
      m_init = (nxt != m_state) && (nxt == LEVEL_1);
      if (nxt != m_state) begin
         m_ticks = 0;
         m_run   = 0;
      end else begin
         m_ticks++;
      end
      m_state = nxt;
      m_pend  = 0;
   endtask

   // mode: 0 none, 1 click pulse at cycle 'at', 2 click on the
   // tick cycle, 3 press at 'at' and keep held.
   // Starts and ends on a negedge with vblnk high.
   task automatic run_frame(input int len, input int mode,
                            input int at,
                            input logic [11:0] cx,
                            input logic [11:0] cy,
                            input logic [11:0] p1,
                            input logic [11:0] p2,
                            input logic [1:0] btn);
      bit prev;
      bit clicked;
      bit win;
      prev = gif.mouse_left;
      gif.vblnk          = 1'b0;
      gif.xpos_mouse     = cx;
      gif.ypos_mouse     = cy;
      gif.xpos_player1   = p1;
      gif.xpos_player2   = p2;
      gif.button_pressed = btn;
      if (mode != 3) gif.mouse_left = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (mode == 1 && i == at) gif.mouse_left = 1'b1;
         if (mode == 1 && i == at + 1) gif.mouse_left = 1'b0;
         if (mode == 3 && i == at) gif.mouse_left = 1'b1;
         @(negedge clk);
      end
      gif.vblnk = 1'b1;
      if (mode == 2) gif.mouse_left = 1'b1;
      clicked = (mode == 1) || (mode == 3 && !prev);
      if (clicked && (m_state == FINISH ||
                      (m_state == START && in_box(cx, cy))))
         m_pend = 1;
      win = (p1 >= 960) && (p2 >= 960) && (btn == 2'b11);
      model_tick(win);
      @(negedge clk);
      o_state = gif.game_state;
      o_fcnt  = gif.frame_cnt;
      o_init  = gif.level_init;
      @(negedge clk);
      o_init2 = gif.level_init;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      gif.vblnk = 1'b1;
      gif.mouse_left = 1'b1;
      gif.xpos_mouse = 12'd512;
      gif.ypos_mouse = 12'd384;
      gif.xpos_player1 = 12'd0;
      gif.xpos_player2 = 12'd0;
      gif.button_pressed = 2'b00;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (gif.game_state !== START || gif.frame_cnt !== 8'd0 ||
          gif.level_init !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got st=%0d fc=%0d li=%0b want 0/0/0",
                  gif.game_state, gif.frame_cnt, gif.level_init);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (gif.game_state !== START || gif.frame_cnt !== 8'd0 ||
          gif.level_init !== 1'b0) begin
         errors++;
         $display("FAIL release_high: got st=%0d fc=%0d li=%0b want 0/0/0",
                  gif.game_state, gif.frame_cnt, gif.level_init);
      end
      run_frame(4, 3, 0, 12'd512, 12'd384, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== START || o_fcnt !== 8'd1) begin
         errors++;
         $display("FAIL held_no_click: got st=%0d fc=%0d want 0/1",
                  o_state, o_fcnt);
      end
   endtask

   task automatic test_start_click();
      run_frame(6, 1, 2, 12'd100, 12'd100, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== START) begin
         errors++;
         $display("FAIL miss_click: got %0d want %0d", o_state, START);
      end
      run_frame(6, 1, 3, 12'd512, 12'd384, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== LEVEL_1 || o_fcnt !== 8'd0) begin
         errors++;
         $display("FAIL hit_click: got st=%0d fc=%0d want %0d/0",
                  o_state, o_fcnt, LEVEL_1);
      end
      checks++;
      if (o_init !== 1'b1 || o_init2 !== 1'b0) begin
         errors++;
         $display("FAIL init_pulse: got %0b,%0b want 1,0",
                  o_init, o_init2);
      end
   endtask

   task automatic win_frames(input int n, input string tag);
      for (int f = 1; f <= n; f++) begin
         run_frame(5, 0, 0, 12'd0, 12'd0, 12'd970, 12'd970, 2'b11);
         checks++;
         if (o_state !== m_state || o_fcnt !== exp_fcnt()) begin
            errors++;
            $display("FAIL %s f%0d: got st=%0d fc=%0d want %0d/%0d",
                     tag, f, o_state, o_fcnt, m_state, exp_fcnt());
         end
      end
   endtask

   task automatic test_level_win();
      win_frames(28, "hold28");
      run_frame(5, 0, 0, 12'd0, 12'd0, 12'd970, 12'd970, 2'b01);
      checks++;
      if (o_state !== LEVEL_1) begin
         errors++;
         $display("FAIL btn_drop: got %0d want %0d", o_state, LEVEL_1);
      end
      for (int f = 1; f <= 30; f++) begin
         run_frame(5, 0, 0, 12'd0, 12'd0, 12'd970, 12'd970, 2'b11);
         checks++;
         if (o_state !== ((f == 30) ? FINISH : LEVEL_1)) begin
            errors++;
            $display("FAIL rehold f%0d: got %0d want %0d", f, o_state,
                     (f == 30) ? FINISH : LEVEL_1);
         end
      end
      checks++;
      if (o_fcnt !== 8'd0 || o_init !== 1'b0) begin
         errors++;
         $display("FAIL finish_entry: got fc=%0d li=%0b want 0/0",
                  o_fcnt, o_init);
      end
   endtask

   task automatic test_finish_timeout();
      for (int f = 1; f <= FIN; f++) begin
         run_frame(3, 0, 0, 12'd0, 12'd0, 12'd0, 12'd0, 2'b00);
         checks++;
         if (o_state !== ((f == FIN) ? START : FINISH)) begin
            errors++;
            $display("FAIL timeout f%0d: got %0d want %0d", f, o_state,
                     (f == FIN) ? START : FINISH);
         end
         if (f == FIN - 1) begin
            checks++;
            if (o_fcnt !== 8'(FIN - 1)) begin
               errors++;
               $display("FAIL fin_cnt: got %0d want %0d", o_fcnt, FIN - 1);
            end
         end
      end
   endtask

   task automatic to_finish();
      run_frame(5, 1, 2, 12'd412, 12'd434, 12'd0, 12'd0, 2'b00);
      win_frames(HOLD, "to_fin");
   endtask

   task automatic test_finish_click();
      to_finish();
      for (int f = 1; f <= 6; f++) begin
         if (f < 6)
            run_frame(5, 0, 0, 12'd0, 12'd0, 12'd0, 12'd0, 2'b00);
         else
            run_frame(5, 1, 2, 12'd100, 12'd100, 12'd0, 12'd0, 2'b00);
         checks++;
         if (o_state !== ((f == 6) ? START : FINISH)) begin
            errors++;
            $display("FAIL fin_click f%0d: got %0d want %0d", f, o_state,
                     (f == 6) ? START : FINISH);
         end
      end
   endtask

   task automatic test_tick_click();
      run_frame(5, 2, 0, 12'd512, 12'd384, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== START) begin
         errors++;
         $display("FAIL tick_click: got %0d want %0d", o_state, START);
      end
      run_frame(5, 0, 0, 12'd512, 12'd384, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== START) begin
         errors++;
         $display("FAIL tick_leak: got %0d want %0d", o_state, START);
      end
   endtask

   task automatic test_held_mouse();
      to_finish();
      run_frame(5, 3, 2, 12'd100, 12'd100, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== START) begin
         errors++;
         $display("FAIL held_fin: got %0d want %0d", o_state, START);
      end
      run_frame(5, 3, 0, 12'd512, 12'd384, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== START) begin
         errors++;
         $display("FAIL held_once: got %0d want %0d", o_state, START);
      end
      run_frame(5, 1, 4, 12'd612, 12'd334, 12'd0, 12'd0, 2'b00);
      checks++;
      if (o_state !== LEVEL_1) begin
         errors++;
         $display("FAIL reclick: got %0d want %0d", o_state, LEVEL_1);
      end
   endtask

   task automatic test_async_reset();
      for (int f = 0; f < 3; f++)
         run_frame(4, 0, 0, 12'd0, 12'd0, 12'd959, 12'd970, 2'b11);
      checks++;
      if (o_state !== LEVEL_1 || o_fcnt !== 8'd3) begin
         errors++;
         $display("FAIL pre_rst: got st=%0d fc=%0d want %0d/3",
                  o_state, o_fcnt, LEVEL_1);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (gif.game_state !== START || gif.frame_cnt !== 8'd0 ||
          gif.level_init !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: got st=%0d fc=%0d li=%0b want 0/0/0",
                  gif.game_state, gif.frame_cnt, gif.level_init);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [11:0] xs[6];
      logic [11:0] ys[6];
      int len, mode, at, r;
      logic [11:0] cx, cy, p1, p2;
      logic [1:0] btn;
      xs = '{12'd411, 12'd412, 12'd512, 12'd612, 12'd613, 12'd0};
      ys = '{12'd333, 12'd334, 12'd384, 12'd434, 12'd435, 12'd0};
      for (int f = 0; f < 250; f++) begin
         len = $urandom_range(2, 8);
         at  = $urandom_range(1, len - 1);
         r   = $urandom_range(0, 9);
         mode = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
         cx = xs[$urandom_range(0, 5)];
         cy = ys[$urandom_range(0, 5)];
         if (cx == 12'd0) cx = 12'($urandom_range(0, 4095));
         if (cy == 12'd0) cy = 12'($urandom_range(0, 4095));
         p1 = 12'($urandom_range(960, 4095));
         p2 = 12'($urandom_range(960, 4095));
         btn = 2'b11;
         if ($urandom_range(0, 99) < 4) begin
            case ($urandom_range(0, 2))
               0: p1 = 12'd959;
               1: p2 = 12'($urandom_range(0, 959));
               default: btn = 2'($urandom_range(0, 2));
            endcase
         end
         run_frame(len, mode, at, cx, cy, p1, p2, btn);
         checks++;
         if (o_state !== m_state || o_fcnt !== exp_fcnt() ||
             o_init !== m_init || o_init2 !== 1'b0) begin
            errors++;
            $display("FAIL rand f%0d: got st=%0d fc=%0d li=%0b,%0b want %0d/%0d/%0b,0",
                     f, o_state, o_fcnt, o_init, o_init2,
                     m_state, exp_fcnt(), m_init);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_click();
      test_level_win();
      test_finish_timeout();
      test_tick_click();
      test_finish_click();
      test_held_mouse();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
